// File: rtl/core_exec_seq_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package core_exec_seq_pkg;

  typedef enum logic [2:0] {
    F_REQ,
    F_WAIT,
    EXEC,
    M_REQ,
    M_WAIT,
    TRAP
  } exec_state_e;

  localparam logic [3:0] CAUSE_MISALIGN    = 4'd0;
  localparam logic [3:0] CAUSE_FETCH_FAULT = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;

endpackage

// File: rtl/core_exec_seq_if.sv
// Instruction-fetch and data-memory request/grant/response buses of the sequencer.
interface core_exec_seq_if;

  logic        ifetch_req;
  logic [31:0] ifetch_addr;
  logic        ifetch_gnt;
  logic        ifetch_rvalid;
  logic [31:0] ifetch_rdata;
  logic        ifetch_err;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic        dmem_err;

  modport master (
    output ifetch_req, ifetch_addr,
    input  ifetch_gnt, ifetch_rvalid, ifetch_rdata, ifetch_err,
    output dmem_req, dmem_we, dmem_addr,
    input  dmem_gnt, dmem_rvalid, dmem_err
  );

  modport slave (
    input  ifetch_req, ifetch_addr,
    output ifetch_gnt, ifetch_rvalid, ifetch_rdata, ifetch_err,
    input  dmem_req, dmem_we, dmem_addr,
    output dmem_gnt, dmem_rvalid, dmem_err
  );

endinterface

// File: rtl/core_next_pc.sv
// Next-PC target selection and alignment check for the instruction in EXEC.
module core_next_pc (
  input  logic [31:0] pc,
  input  logic [31:0] imm_val,
  input  logic [31:0] alu_result,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        branch_taken,
  output logic [31:0] target,
  output logic        misaligned
);

  always_comb begin
    // NOTE: default assignment first keeps this block purely combinational (no latch).
    target = pc + 32'd4;
    if (is_jalr) begin
      target = {alu_result[31:1], 1'b0};
    end else if (is_jal || (is_branch && branch_taken)) begin
      target = pc + imm_val;
    end
  end

  assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/core_exec_seq.sv
// Multi-cycle sequencer: fetch, execute, data-memory access, retire and trap; owns the PC.
module core_exec_seq
  import core_exec_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h8000_0004
) (
  input  logic                   clk,
  input  logic                   rst,
  core_exec_seq_if.master        bus,
  output logic [31:0]            instr,
  input  logic                   dec_illegal,
  input  logic                   dec_is_load,
  input  logic                   dec_is_store,
  input  logic                   dec_is_branch,
  input  logic                   dec_is_jal,
  input  logic                   dec_is_jalr,
  input  logic                   dec_rd_we,
  input  logic [31:0]            imm_val,
  input  logic [31:0]            alu_result,
  input  logic                   branch_taken,
  output logic [31:0]            pc,
  output logic                   rd_we,
  output logic                   retire,
  output logic                   trap_valid,
  output logic [3:0]             trap_cause,
  output logic [31:0]            trap_tval
);

  exec_state_e state;
  logic        ifetch_req_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic [31:0] dmem_addr_q;
  logic        load_wb_q;
  logic [31:0] target;
  logic        misaligned;

  core_next_pc u_next_pc (
    .pc           (pc),
    .imm_val      (imm_val),
    .alu_result   (alu_result),
    .is_branch    (dec_is_branch),
    .is_jal       (dec_is_jal),
    .is_jalr      (dec_is_jalr),
    .branch_taken (branch_taken),
    .target       (target),
    .misaligned   (misaligned)
  );

  assign bus.ifetch_req  = ifetch_req_q;
  assign bus.ifetch_addr = pc;
  assign bus.dmem_req    = dmem_req_q;
  assign bus.dmem_we     = dmem_we_q;
  assign bus.dmem_addr   = dmem_addr_q;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= F_REQ;
      pc           <= RESET_PC;
      instr        <= '0;
      ifetch_req_q <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      load_wb_q    <= 1'b0;
      rd_we        <= 1'b0;
      retire       <= 1'b0;
      trap_valid   <= 1'b0;
      trap_cause   <= '0;
      trap_tval    <= '0;
    end else begin
      rd_we      <= 1'b0;
      retire     <= 1'b0;
      trap_valid <= 1'b0;

      unique case (state)
        F_REQ: begin
          // The request register rises one cycle after reset; a grant only counts once it is up.
          ifetch_req_q <= 1'b1;
          if (ifetch_req_q && bus.ifetch_gnt) begin
            ifetch_req_q <= 1'b0;
            state        <= F_WAIT;
          end
        end

        F_WAIT: begin
          if (bus.ifetch_rvalid) begin
            instr <= bus.ifetch_rdata;
            if (bus.ifetch_err) begin
              trap_valid <= 1'b1;
              trap_cause <= CAUSE_FETCH_FAULT;
              trap_tval  <= pc;
              state      <= TRAP;
            end else begin
              state <= EXEC;
            end
          end
        end

        EXEC: begin
          if (dec_illegal) begin
            trap_valid <= 1'b1;
            trap_cause <= CAUSE_ILLEGAL;
            trap_tval  <= instr;
            state      <= TRAP;
          end else if (dec_is_load || dec_is_store) begin
            dmem_addr_q <= alu_result;
            dmem_we_q   <= dec_is_store;
            dmem_req_q  <= 1'b1;
            load_wb_q   <= dec_is_load & dec_rd_we;
            state       <= M_REQ;
          end else if (misaligned) begin
            trap_valid <= 1'b1;
            trap_cause <= CAUSE_MISALIGN;
            trap_tval  <= target;
            state      <= TRAP;
          end else begin
            rd_we        <= dec_rd_we;
            retire       <= 1'b1;
            pc           <= target;
            ifetch_req_q <= 1'b1;
            state        <= F_REQ;
          end
        end

        M_REQ: begin
          if (bus.dmem_gnt) begin
            dmem_req_q <= 1'b0;
            state      <= M_WAIT;
          end
        end

        M_WAIT: begin
          if (bus.dmem_rvalid) begin
            if (bus.dmem_err) begin
              trap_valid <= 1'b1;
              trap_cause <= dmem_we_q ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
              trap_tval  <= dmem_addr_q;
              state      <= TRAP;
            end else begin
              rd_we        <= load_wb_q;
              retire       <= 1'b1;
              pc           <= pc + 32'd4;
              ifetch_req_q <= 1'b1;
              state        <= F_REQ;
            end
          end
        end

        TRAP: begin
          pc           <= TRAP_VEC;
          ifetch_req_q <= 1'b1;
          state        <= F_REQ;
        end

        default: state <= F_REQ;
      endcase
    end
  end

endmodule
